// File: rtl/encoder_8_3_queue_pkg.sv
// encoder_8_3_queue_pkg: shared sizing defaults and index/vector types for the 8-to-3 encoder queue.
package encoder_8_3_queue_pkg;
   localparam int ENC_IN  = 8;
   localparam int ENC_OUT = 3;
   typedef logic [ENC_OUT-1:0] enc_idx_t;
   typedef logic [ENC_IN-1:0]  enc_vec_t;
endpackage

// File: rtl/encoder_8_3_queue_if.sv
// encoder_8_3_queue_if: event capture inputs plus valid/ready index output of the encoder queue.
interface encoder_8_3_queue_if
   import encoder_8_3_queue_pkg::*;
#(
   parameter int IN  = ENC_IN,
   parameter int OUT = ENC_OUT
);
   logic           enable;
   logic [IN-1:0]  in;
   logic [OUT-1:0] out;
   logic           valid;
   logic           ready;
   logic [OUT:0]   pending_cnt;
   logic           overflow;
   modport master (output enable, in, ready, input out, valid, pending_cnt, overflow);
   modport slave  (input enable, in, ready, output out, valid, pending_cnt, overflow);
endinterface

// File: rtl/encoder_8_3_queue_prio_pick.sv
// prio_pick: rotating priority selector, first set req bit at or above base, wrapping at IN-1.
module prio_pick
   import encoder_8_3_queue_pkg::*;
#(
   parameter int IN  = ENC_IN,
   parameter int OUT = ENC_OUT
) (
   input  logic [IN-1:0]  req,
   input  logic [OUT-1:0] base,
   output logic [OUT-1:0] sel,
   output logic           any
);
   logic [2*IN-1:0] rot;
   logic [OUT-1:0]  k;
   always_comb begin
      rot = {req, req} >> base;
      k = '0;
      for (int i = IN - 1; i >= 0; i--)
         if (rot[i]) k = OUT'(i);
      sel = base + k;
      any = |req;
   end
endmodule

// File: rtl/encoder_8_3_queue.sv
// encoder_8_3_queue: captures multi-hot events into a pending set and emits one index per transfer.
// Set wins over clear, so an event on the index being presented re-arms it without overflow.
module encoder_8_3_queue
   import encoder_8_3_queue_pkg::*;
#(
   parameter int IN  = ENC_IN,
   parameter int OUT = ENC_OUT,
   parameter int RR  = 0
) (
   input logic               clk,
   input logic               rst_n,
   encoder_8_3_queue_if.slave bus
);
   logic [IN-1:0]  pending_q, pending_d, clr;
   logic [OUT-1:0] out_q, ptr_q, sel, base;
   logic [OUT:0]   cnt;
   logic           valid_q, overflow_q, any, load;
   prio_pick #(.IN(IN), .OUT(OUT)) u_pick (
      .req (pending_q),
      .base(base),
      .sel (sel),
      .any (any)
   );
   always_comb begin
      base = (RR != 0) ? ptr_q : '0;
      load = !valid_q || bus.ready;
      clr = (load && any) ? (IN'(1) << sel) : '0;
      pending_d = (pending_q & ~clr) | (bus.enable ? bus.in : '0);
      cnt = '0;
      for (int i = 0; i < IN; i++) cnt = cnt + (OUT+1)'(pending_q[i]);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q  <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         ptr_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= bus.enable && |(bus.in & pending_q & ~clr);
         if (load) begin
            valid_q <= any;
            if (any) begin
               out_q <= sel;
               ptr_q <= sel + OUT'(1);
            end
         end
      end
   end
   assign bus.out         = out_q;
   assign bus.valid       = valid_q;
   assign bus.pending_cnt = cnt;
   assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_encoder_8_3_queue.sv
// tb_encoder_8_3_queue: directed scenarios on a fixed-priority and a round-robin instance.
module tb_encoder_8_3_queue;
   import encoder_8_3_queue_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   encoder_8_3_queue_if #(.IN(8), .OUT(3)) a0 ();
   encoder_8_3_queue_if #(.IN(8), .OUT(3)) a1 ();
   encoder_8_3_queue #(.IN(8), .OUT(3), .RR(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(a0));
   encoder_8_3_queue #(.IN(8), .OUT(3), .RR(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(a1));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a0.enable = 1'b0; a0.in = '0; a0.ready = 1'b1;
      a1.enable = 1'b0; a1.in = '0; a1.ready = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (20) tick();
      checks++; if (a0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b want 0", a0.valid); end
      checks++; if (a0.out !== 3'd0) begin errors++; $display("FAIL reset_out0 got %0d want 0", a0.out); end
      checks++; if (a0.pending_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt0 got %0d want 0", a0.pending_cnt); end
      checks++; if (a0.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf0 got %b want 0", a0.overflow); end
      checks++; if (a1.valid !== 1'b0 || a1.out !== 3'd0 || a1.pending_cnt !== 4'd0 || a1.overflow !== 1'b0) begin
         errors++; $display("FAIL reset_rr got valid=%b out=%0d cnt=%0d ovf=%b want all 0", a1.valid, a1.out, a1.pending_cnt, a1.overflow);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fixed_priority();
      logic [2:0] exp_out [3] = '{3'd2, 3'd5, 3'd7};
      logic [3:0] exp_cnt [3] = '{4'd2, 4'd1, 4'd0};
      do_reset();
      a0.enable = 1'b1; a0.in = 8'b1010_0100;
      tick();
      a0.in = 8'h00;
      checks++; if (a0.pending_cnt !== 4'd3 || a0.valid !== 1'b0) begin
         errors++; $display("FAIL fp_capture got cnt=%0d valid=%b want cnt=3 valid=0", a0.pending_cnt, a0.valid);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (a0.valid !== 1'b1 || a0.out !== exp_out[k] || a0.pending_cnt !== exp_cnt[k]) begin
            errors++; $display("FAIL fp_emit%0d got valid=%b out=%0d cnt=%0d want 1 %0d %0d", k, a0.valid, a0.out, a0.pending_cnt, exp_out[k], exp_cnt[k]);
         end
      end
      tick();
      checks++; if (a0.valid !== 1'b0) begin errors++; $display("FAIL fp_drained got valid=%b want 0", a0.valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      a0.enable = 1'b1; a0.in = 8'b1010_0100;
      tick();
      a0.in = 8'h00;
      tick();
      tick();
      checks++; if (a0.out !== 3'd5 || a0.valid !== 1'b1) begin errors++; $display("FAIL bp_pre got out=%0d valid=%b want 5 1", a0.out, a0.valid); end
      a0.ready = 1'b0; a0.in = 8'h01;
      tick();
      a0.in = 8'h00;
      checks++; if (a0.out !== 3'd5 || a0.valid !== 1'b1 || a0.pending_cnt !== 4'd2) begin
         errors++; $display("FAIL bp_hold1 got out=%0d valid=%b cnt=%0d want 5 1 2", a0.out, a0.valid, a0.pending_cnt);
      end
      tick();
      checks++; if (a0.out !== 3'd5 || a0.valid !== 1'b1) begin errors++; $display("FAIL bp_hold2 got out=%0d valid=%b want 5 1", a0.out, a0.valid); end
      a0.ready = 1'b1;
      tick();
      checks++; if (a0.out !== 3'd0 || a0.valid !== 1'b1) begin errors++; $display("FAIL bp_next got out=%0d valid=%b want 0 1", a0.out, a0.valid); end
      tick();
      checks++; if (a0.out !== 3'd7 || a0.valid !== 1'b1) begin errors++; $display("FAIL bp_last got out=%0d valid=%b want 7 1", a0.out, a0.valid); end
      tick();
      checks++; if (a0.valid !== 1'b0) begin errors++; $display("FAIL bp_drained got valid=%b want 0", a0.valid); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp;
      do_reset();
      a1.enable = 1'b1; a1.in = 8'hFF; a1.ready = 1'b1;
      tick();
      checks++; if (a1.pending_cnt !== 4'd8 || a1.valid !== 1'b0 || a1.overflow !== 1'b0) begin
         errors++; $display("FAIL rr_capture got cnt=%0d valid=%b ovf=%b want 8 0 0", a1.pending_cnt, a1.valid, a1.overflow);
      end
      for (int k = 1; k <= 10; k++) begin
         if (k == 10) a1.in = 8'h00;
         tick();
         exp = 3'((k - 1) % 8);
         checks++; if (a1.valid !== 1'b1 || a1.out !== exp) begin
            errors++; $display("FAIL rr_out%0d got valid=%b out=%0d want 1 %0d", k, a1.valid, a1.out, exp);
         end
         checks++; if (a1.overflow !== (k <= 9)) begin
            errors++; $display("FAIL rr_ovf%0d got %b want %b", k, a1.overflow, (k <= 9));
         end
      end
      repeat (8) tick();
      checks++; if (a1.valid !== 1'b0 || a1.pending_cnt !== 4'd0) begin
         errors++; $display("FAIL rr_drained got valid=%b cnt=%0d want 0 0", a1.valid, a1.pending_cnt);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      a0.enable = 1'b1; a0.ready = 1'b0; a0.in = 8'h01;
      tick();
      a0.in = 8'h00;
      tick();
      a0.in = 8'h10;
      tick();
      checks++; if (a0.overflow !== 1'b0 || a0.pending_cnt !== 4'd1) begin
         errors++; $display("FAIL ovf_first got ovf=%b cnt=%0d want 0 1", a0.overflow, a0.pending_cnt);
      end
      tick();
      a0.in = 8'h00;
      checks++; if (a0.overflow !== 1'b1 || a0.pending_cnt !== 4'd1) begin
         errors++; $display("FAIL ovf_merge got ovf=%b cnt=%0d want 1 1", a0.overflow, a0.pending_cnt);
      end
      tick();
      checks++; if (a0.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %b want 0", a0.overflow); end
      a0.ready = 1'b1;
      tick();
      checks++; if (a0.out !== 3'd4 || a0.valid !== 1'b1) begin errors++; $display("FAIL ovf_emit got out=%0d valid=%b want 4 1", a0.out, a0.valid); end
      tick();
      checks++; if (a0.valid !== 1'b0) begin errors++; $display("FAIL ovf_once got valid=%b want 0", a0.valid); end
      a0.ready = 1'b0; a0.in = 8'h10;
      tick();
      tick();
      checks++; if (a0.out !== 3'd4 || a0.valid !== 1'b1 || a0.pending_cnt !== 4'd1) begin
         errors++; $display("FAIL rearm_pres got out=%0d valid=%b cnt=%0d want 4 1 1", a0.out, a0.valid, a0.pending_cnt);
      end
      checks++; if (a0.overflow !== 1'b0) begin errors++; $display("FAIL rearm_ovf got %b want 0", a0.overflow); end
      a0.in = 8'h00; a0.ready = 1'b1;
      tick();
      checks++; if (a0.out !== 3'd4 || a0.valid !== 1'b1) begin errors++; $display("FAIL rearm_emit got out=%0d valid=%b want 4 1", a0.out, a0.valid); end
      tick();
      checks++; if (a0.valid !== 1'b0) begin errors++; $display("FAIL rearm_done got valid=%b want 0", a0.valid); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      a0.enable = 1'b1; a0.ready = 1'b0; a0.in = 8'h0F;
      tick();
      a0.in = 8'h00;
      tick();
      checks++; if (a0.valid !== 1'b1 || a0.pending_cnt !== 4'd3) begin
         errors++; $display("FAIL mid_setup got valid=%b cnt=%0d want 1 3", a0.valid, a0.pending_cnt);
      end
      rst_n = 1'b0; a0.in = 8'hFF;
      tick();
      checks++; if (a0.valid !== 1'b0 || a0.out !== 3'd0 || a0.pending_cnt !== 4'd0 || a0.overflow !== 1'b0) begin
         errors++; $display("FAIL mid_reset got valid=%b out=%0d cnt=%0d ovf=%b want all 0", a0.valid, a0.out, a0.pending_cnt, a0.overflow);
      end
      rst_n = 1'b1; a0.in = 8'h00; a0.ready = 1'b1;
      tick();
      checks++; if (a0.pending_cnt !== 4'd0 || a0.valid !== 1'b0) begin
         errors++; $display("FAIL mid_dropped got cnt=%0d valid=%b want 0 0", a0.pending_cnt, a0.valid);
      end
      a0.enable = 1'b0; a0.in = 8'hFF;
      tick();
      tick();
      checks++; if (a0.pending_cnt !== 4'd0 || a0.valid !== 1'b0 || a0.overflow !== 1'b0) begin
         errors++; $display("FAIL enable_off got cnt=%0d valid=%b ovf=%b want 0 0 0", a0.pending_cnt, a0.valid, a0.overflow);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_fixed_priority();
      test_backpressure();
      test_round_robin();
      test_overflow();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
